// File: rtl/isr_sched_pkg.sv
// Shared types and default sizes for the square-root core scheduler.
package isr_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int DEF_NREQ    = 4;
   localparam int DEF_DIN_W   = 256;
   localparam int DEF_VOUT_W  = 128;
   localparam int DEF_ROUT_W  = 129;
   localparam int DEF_TIMEOUT = 512;

   function automatic int wrap_idx(input int i, input int n);
      return (i >= n) ? i - n : i;
   endfunction

endpackage

// File: rtl/isr_rr_arb.sv
// Combinational round-robin picker: first valid requester strictly after ptr, wrapping.
module isr_rr_arb
   import isr_sched_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
)(
   input  logic [NREQ-1:0]         valid,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any
);

   localparam int IDX_W = $clog2(NREQ);

   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         j = wrap_idx(int'(ptr) + k, NREQ);
         if (!any && valid[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/isr_sched.sv
// Shares one integer-square-root core among NREQ requesters: round-robin grant,
// one operation in flight, per-operation watchdog.
module isr_sched
   import isr_sched_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int DIN_W   = DEF_DIN_W,
   parameter int VOUT_W  = DEF_VOUT_W,
   parameter int ROUT_W  = DEF_ROUT_W,
   parameter int TIMEOUT = DEF_TIMEOUT
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*DIN_W-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic [DIN_W-1:0]        core_din,
   output logic                    core_calcen,
   output logic                    core_clken,
   input  logic [VOUT_W-1:0]       core_vout,
   input  logic [ROUT_W-1:0]       core_rout,
   input  logic                    core_calcend,
   input  logic                    core_idle,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [VOUT_W-1:0]       rsp_root,
   output logic [ROUT_W-1:0]       rsp_rem,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    err_sticky
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int WD_W  = $clog2(TIMEOUT);

   state_t            state;
   logic [IDX_W-1:0]  ptr;
   logic [WD_W-1:0]   wdog;
   logic [NREQ-1:0]   grant;
   logic [IDX_W-1:0]  grant_idx;
   logic              grant_any;
   logic              take;

   isr_rr_arb #(.NREQ(NREQ)) u_arb (
      .valid (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   // Accept is combinational so the requester sees it in the same cycle its data is captured.
   assign take      = (state == IDLE) && grant_any && core_idle && !reset;
   assign req_ready = take ? grant : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= IDX_W'(NREQ - 1);
         wdog        <= '0;
         core_din    <= '0;
         core_calcen <= 1'b0;
         core_clken  <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_root    <= '0;
         rsp_rem     <= '0;
         rsp_err     <= 1'b0;
         err_sticky  <= 1'b0;
      end else begin
         core_clken  <= 1'b1;
         core_calcen <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  core_din    <= req_data[int'(grant_idx)*DIN_W +: DIN_W];
                  rsp_id      <= grant_idx;
                  ptr         <= grant_idx;
                  core_calcen <= 1'b1;
                  state       <= LAUNCH;
               end
            end
            LAUNCH: begin
               wdog  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // A calcend arriving on the final watchdog cycle still counts as success.
               if (core_calcend) begin
                  rsp_root  <= core_vout;
                  rsp_rem   <= core_rout;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                  rsp_root   <= '0;
                  rsp_rem    <= '0;
                  rsp_err    <= 1'b1;
                  err_sticky <= 1'b1;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_isr_sched.sv
// Directed bench for isr_sched with a behavioural stand-in for the sqrt core.
module tb_isr_sched;

   localparam int NREQ    = 4;
   localparam int DIN_W   = 256;
   localparam int VOUT_W  = 128;
   localparam int ROUT_W  = 129;
   localparam int TIMEOUT = 16;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NREQ-1:0]         req_valid;
   logic [NREQ*DIN_W-1:0]   req_data;
   logic [NREQ-1:0]         req_ready;
   logic [DIN_W-1:0]        core_din;
   logic                    core_calcen;
   logic                    core_clken;
   logic [VOUT_W-1:0]       core_vout;
   logic [ROUT_W-1:0]       core_rout;
   logic                    core_calcend;
   logic                    core_idle;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [1:0]              rsp_id;
   logic [VOUT_W-1:0]       rsp_root;
   logic [ROUT_W-1:0]       rsp_rem;
   logic                    rsp_err;
   logic                    busy;
   logic                    err_sticky;

   int checks = 0;
   int errors = 0;
   int calcen_cnt = 0;

   // core stand-in controls
   logic       hang;
   logic       idle_force;
   int         lat;
   logic       running;
   int         cnt;
   logic [DIN_W-1:0] din_cap;

   localparam logic [VOUT_W-1:0] ROOT_MAX = {VOUT_W{1'b1}};
   localparam logic [ROUT_W-1:0] REM_MAX  = {{(ROUT_W-1){1'b1}}, 1'b0};

   isr_sched #(
      .NREQ(NREQ), .DIN_W(DIN_W), .VOUT_W(VOUT_W), .ROUT_W(ROUT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .core_din(core_din), .core_calcen(core_calcen), .core_clken(core_clken),
      .core_vout(core_vout), .core_rout(core_rout), .core_calcend(core_calcend),
      .core_idle(core_idle),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_root(rsp_root), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
      .busy(busy), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   function automatic logic [VOUT_W+ROUT_W-1:0] model_sqrt(input logic [DIN_W-1:0] x);
      logic [VOUT_W-1:0] r;
      logic [ROUT_W-1:0] m;
      longint unsigned   v;
      longint unsigned   q;
      if (&x) begin
         r = ROOT_MAX;
         m = REM_MAX;
      end else begin
         v = x[63:0];
         q = 0;
         while ((q + 1) * (q + 1) <= v) q++;
         r = VOUT_W'(q);
         m = ROUT_W'(v - q * q);
      end
      return {r, m};
   endfunction

   assign core_idle = idle_force && !running;

   always @(posedge clk) begin
      if (core_calcen) calcen_cnt <= calcen_cnt + 1;
      if (reset) begin
         running      <= 1'b0;
         core_calcend <= 1'b0;
         cnt          <= 0;
         core_vout    <= '0;
         core_rout    <= '0;
         din_cap      <= '0;
      end else begin
         core_calcend <= 1'b0;
         if (core_calcen) begin
            running <= 1'b1;
            cnt     <= lat - 1;
            din_cap <= core_din;
         end else if (running && !hang) begin
            if (cnt == 0) begin
               running                  <= 1'b0;
               core_calcend             <= 1'b1;
               {core_vout, core_rout}   <= model_sqrt(din_cap);
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int maxc);
      #1;
      for (int i = 0; i < maxc && req_ready == '0; i++) step();
   endtask

   task automatic wait_rsp(input int maxc, output int n, output logic pc);
      n  = 0;
      pc = 1'b0;
      while (!rsp_valid && n < maxc) begin
         pc = core_calcend;
         step();
         n++;
      end
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      int   n;
      int   c0;
      logic pc;

      reset      = 1'b1;
      req_valid  = '0;
      req_data   = '0;
      rsp_ready  = 1'b0;
      hang       = 1'b0;
      idle_force = 1'b1;
      lat        = 3;

      // Reset state, with requests already pending
      for (int i = 0; i < NREQ; i++) req_data[i*DIN_W +: DIN_W] = DIN_W'((i + 4) * (i + 4));
      req_valid = 4'b1111;
      step(); step();
      chk("rst_clken", core_clken, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_calcen", core_calcen, 0);
      chk("rst_err_sticky", err_sticky, 0);
      chk("rst_root", rsp_root, 0);
      reset = 1'b0;

      // All requesters valid: grants rotate 0,1,2,3,0
      c0 = calcen_cnt;
      for (int k = 0; k < 5; k++) begin
         wait_grant(20);
         chk($sformatf("rr_grant%0d", k), req_ready, 4'b0001 << (k % 4));
         step();
         if (k == 0) chk("rr_clken", core_clken, 1);
         chk($sformatf("rr_calcen%0d", k), core_calcen, 1);
         wait_rsp(50, n, pc);
         chk($sformatf("rr_valid%0d", k), rsp_valid, 1);
         chk($sformatf("rr_id%0d", k), rsp_id, k % 4);
         chk($sformatf("rr_root%0d", k), rsp_root, 4 + (k % 4));
         handshake();
         if (k == 4) req_valid = '0;
      end
      step();
      chk("rr_calcen_count", calcen_cnt - c0, 5);

      // Single request 0, radicand 144
      req_data[0 +: DIN_W] = 144;
      req_valid = 4'b0001;
      wait_grant(20);
      chk("one_ready", req_ready, 4'b0001);
      step();
      req_valid = '0;
      chk("one_calcen", core_calcen, 1);
      chk("one_din", core_din, 144);
      chk("one_busy", busy, 1);
      step();
      chk("one_calcen_pulse", core_calcen, 0);
      wait_rsp(50, n, pc);
      chk("one_valid", rsp_valid, 1);
      chk("one_after_calcend", pc, 1);
      chk("one_root", rsp_root, 12);
      chk("one_rem", rsp_rem, 0);
      chk("one_id", rsp_id, 0);
      chk("one_err", rsp_err, 0);
      handshake();
      chk("one_valid_clr", rsp_valid, 0);
      chk("one_busy_clr", busy, 0);

      // Consumer stalls: response held, no new accept
      req_data[1*DIN_W +: DIN_W] = 103;
      req_valid = 4'b0010;
      wait_grant(20);
      chk("stall_ready", req_ready, 4'b0010);
      step();
      req_valid = 4'b0100;
      wait_rsp(50, n, pc);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall_valid", rsp_valid, 1);
         chk("stall_root", rsp_root, 10);
         chk("stall_rem", rsp_rem, 3);
         chk("stall_no_ready", req_ready, 0);
      end
      req_valid = '0;
      handshake();
      chk("stall_valid_clr", rsp_valid, 0);

      // Core never finishes: watchdog abort
      req_data[3*DIN_W +: DIN_W] = 9;
      hang = 1'b1;
      req_valid = 4'b1000;
      wait_grant(20);
      chk("to_ready", req_ready, 4'b1000);
      step();
      req_valid = '0;
      chk("to_calcen", core_calcen, 1);
      wait_rsp(TIMEOUT + 10, n, pc);
      chk("to_latency", n, TIMEOUT + 1);
      chk("to_err", rsp_err, 1);
      chk("to_root", rsp_root, 0);
      chk("to_rem", rsp_rem, 0);
      chk("to_sticky", err_sticky, 1);
      chk("to_id", rsp_id, 3);
      hang = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("to_late_calcend_ignored", rsp_root, 0);
      chk("to_late_err_held", rsp_err, 1);
      handshake();

      // calcend on the last watchdog cycle wins
      lat = TIMEOUT - 1;
      req_valid = 4'b1000;
      wait_grant(20);
      step();
      req_valid = '0;
      wait_rsp(TIMEOUT + 10, n, pc);
      chk("edge_latency", n, TIMEOUT + 1);
      chk("edge_calcend", pc, 1);
      chk("edge_err", rsp_err, 0);
      chk("edge_root", rsp_root, 3);
      chk("edge_sticky", err_sticky, 1);
      handshake();

      // calcend one cycle too late aborts
      lat = TIMEOUT;
      req_valid = 4'b1000;
      wait_grant(20);
      step();
      req_valid = '0;
      wait_rsp(TIMEOUT + 10, n, pc);
      chk("late_latency", n, TIMEOUT + 1);
      chk("late_err", rsp_err, 1);
      step(); step();
      chk("late_root", rsp_root, 0);
      handshake();
      lat = 3;

      // Reset while waiting on the core
      req_data[0 +: DIN_W] = 64;
      hang = 1'b1;
      req_valid = 4'b0001;
      wait_grant(20);
      step();
      req_valid = '0;
      step(); step();
      chk("rw_busy_before", busy, 1);
      reset = 1'b1;
      step();
      chk("rw_busy", busy, 0);
      chk("rw_rsp_valid", rsp_valid, 0);
      chk("rw_clken", core_clken, 0);
      chk("rw_sticky", err_sticky, 0);
      reset = 1'b0;
      hang  = 1'b0;
      req_valid = 4'b1111;
      wait_grant(20);
      chk("rw_ptr_reset", req_ready, 4'b0001);
      step();
      req_valid = '0;
      chk("rw_clken_back", core_clken, 1);
      wait_rsp(50, n, pc);
      chk("rw_root", rsp_root, 8);
      chk("rw_id", rsp_id, 0);
      handshake();

      // Core busy blocks grants; full-width radicand
      idle_force = 1'b0;
      req_data[2*DIN_W +: DIN_W] = {DIN_W{1'b1}};
      req_valid = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_no_ready", req_ready, 0);
         chk("idle_not_busy", busy, 0);
      end
      idle_force = 1'b1;
      wait_grant(20);
      chk("idle_ready", req_ready, 4'b0100);
      step();
      req_valid = '0;
      chk("max_din", core_din, {DIN_W{1'b1}});
      wait_rsp(50, n, pc);
      chk("max_valid", rsp_valid, 1);
      chk("max_root", rsp_root, ROOT_MAX);
      chk("max_rem", rsp_rem, REM_MAX);
      chk("max_id", rsp_id, 2);
      handshake();
      chk("max_done", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
